// File: rtl/cpu_defs.sv
// Shared CPU decode-stage definitions: GPR addressing, scoreboard entry format
// and the source/destination match helper used by the hazard logic.
package cpu_defs;

    localparam int GPR_AW    = 5;
    localparam int GPR_NUM   = 32;
    localparam int LAT_W_DEF = 4;

    // Countdown storage covers the widest supported LAT_W; narrower configurations keep the top bits at zero.
    localparam int SB_CNT_W  = 8;

    typedef struct packed {
        logic                pending;
        logic                is_var;
        logic [SB_CNT_W-1:0] cnt;
    } sb_entry_t;

    localparam sb_entry_t SB_ENTRY_EMPTY = '{pending: 1'b0, is_var: 1'b0, cnt: '0};

    // A source only creates a dependency when it names a real register ($0 is hardwired zero).
    function automatic logic src_match(input logic [GPR_AW-1:0] src, input logic [GPR_AW-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/cpu_sb_entry.sv
// One GPR scoreboard entry: pending flag with either a fixed-latency countdown
// or a wait for a variable-latency completion.
module cpu_sb_entry
    import cpu_defs::*;
#(
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_hold,
    input  logic             i_issue,
    input  logic [LAT_W-1:0] i_issue_lat,
    input  logic             i_cmpl_hit,
    output logic             o_pending
);

    sb_entry_t r_entry;
    sb_entry_t w_entry_nxt;

    always_comb begin
        // NOTE: the default assignment first keeps this block free of inferred latches.
        w_entry_nxt = r_entry;
        if (i_flush) begin
            w_entry_nxt = SB_ENTRY_EMPTY;
        end else if (i_issue) begin
            // A fresh writer overrides any expiry or completion landing in the same cycle.
            w_entry_nxt.pending = 1'b1;
            if (i_issue_lat != '0) begin
                w_entry_nxt.cnt    = SB_CNT_W'(i_issue_lat);
                w_entry_nxt.is_var = 1'b0;
            end else begin
                w_entry_nxt.is_var = 1'b1;
            end
        end else if (r_entry.pending) begin
            if (r_entry.is_var) begin
                if (i_cmpl_hit) begin
                    w_entry_nxt = SB_ENTRY_EMPTY;
                end
            end else if (!i_hold) begin
                if (r_entry.cnt <= SB_CNT_W'(1)) begin
                    w_entry_nxt = SB_ENTRY_EMPTY;
                end else begin
                    w_entry_nxt.cnt = r_entry.cnt - SB_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) begin
            r_entry <= SB_ENTRY_EMPTY;
        end else begin
            r_entry <= w_entry_nxt;
        end
    end

    assign o_pending = r_entry.pending;

endmodule

// File: rtl/cpu_id_scoreboard.sv
// Decode-stage register scoreboard: in-order prefix acceptance of a decode
// bundle against pending GPR writers, with fixed and variable result latency.
module cpu_id_scoreboard
    import cpu_defs::*;
#(
    parameter int ISSUE_W = 2,
    parameter int LAT_W   = LAT_W_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ISSUE_W-1:0]                lane_valid,
    input  logic [ISSUE_W-1:0][GPR_AW-1:0]    lane_raddr1,
    input  logic [ISSUE_W-1:0][GPR_AW-1:0]    lane_raddr2,
    input  logic [ISSUE_W-1:0]                lane_we,
    input  logic [ISSUE_W-1:0][GPR_AW-1:0]    lane_waddr,
    input  logic [ISSUE_W-1:0][LAT_W-1:0]     lane_lat,
    input  logic                              hold,
    input  logic                              flush,
    input  logic                              cmpl_valid,
    input  logic [GPR_AW-1:0]                 cmpl_waddr,
    output logic [$clog2(ISSUE_W+1)-1:0]      issue_cnt,
    output logic                              stall_req,
    output logic [GPR_NUM-1:0]                busy
);

    localparam int CNT_W = $clog2(ISSUE_W+1);

    logic [GPR_NUM-1:0]              w_busy;
    logic [ISSUE_W-1:0]              w_lane_ok;
    logic [ISSUE_W-1:0]              w_accept;
    logic [CNT_W-1:0]                w_issue_cnt;
    logic                            w_stop;
    logic [GPR_NUM-1:1]              w_reg_issue;
    logic [GPR_NUM-1:1][LAT_W-1:0]   w_reg_lat;

    // A lane is clean when its sources are not pending and not written by an older lane of the same bundle.
    always_comb begin
        w_lane_ok = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            w_lane_ok[i] = lane_valid[i] && !w_busy[lane_raddr1[i]] && !w_busy[lane_raddr2[i]];
            for (int j = 0; j < i; j++) begin
                if (lane_we[j] && (src_match(lane_raddr1[i], lane_waddr[j]) ||
                                   src_match(lane_raddr2[i], lane_waddr[j]))) begin
                    w_lane_ok[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_issue_cnt = '0;
        w_stop      = hold || flush;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (!w_stop) begin
                if (w_lane_ok[i]) begin
                    w_issue_cnt = CNT_W'(i + 1);
                end else begin
                    w_stop = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            w_accept[i] = (i < int'(w_issue_cnt));
        end
    end

    // Later lanes overwrite earlier ones, so the youngest accepted writer of a register sets its entry.
    always_comb begin
        w_reg_issue = '0;
        w_reg_lat   = '0;
        for (int r = 1; r < GPR_NUM; r++) begin
            for (int i = 0; i < ISSUE_W; i++) begin
                if (w_accept[i] && lane_we[i] && (lane_waddr[i] == GPR_AW'(r))) begin
                    w_reg_issue[r] = 1'b1;
                    w_reg_lat[r]   = lane_lat[i];
                end
            end
        end
    end

    assign w_busy[0] = 1'b0;

    for (genvar r = 1; r < GPR_NUM; r++) begin : g_gpr
        cpu_sb_entry #(
            .LAT_W (LAT_W)
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .i_flush     (flush),
            .i_hold      (hold),
            .i_issue     (w_reg_issue[r]),
            .i_issue_lat (w_reg_lat[r]),
            .i_cmpl_hit  (cmpl_valid && (cmpl_waddr == GPR_AW'(r))),
            .o_pending   (w_busy[r])
        );
    end

    assign issue_cnt = w_issue_cnt;
    assign stall_req = lane_valid[0] && (w_issue_cnt == '0);
    assign busy      = w_busy;

endmodule

// File: doc/cpu_id_scoreboard.md
CPU_ID_SCOREBOARD -- requirements
Module: cpu_id_scoreboard

Interface
REQ-001 Parameter ISSUE_W, default 2, meaning number of decode lanes per bundle (legal 1..4).
REQ-002 Parameter LAT_W, default 4, meaning width of per-register latency countdown (max fixed latency 2^LAT_W-1).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 lane_valid  input  ISSUE_W  lane i holds a decoded instruction.
REQ-006 lane_raddr1, lane_raddr2  input  ISSUE_W x 5  source GPR addresses per lane.
REQ-007 lane_we  input  ISSUE_W  lane writes a GPR.
REQ-008 lane_waddr  input  ISSUE_W x 5  destination GPR per lane.
REQ-009 lane_lat  input  ISSUE_W x LAT_W  cycles until result is forwardable; 0 = variable latency, wait for cmpl.
REQ-010 hold  input  1  downstream pipeline freeze.
REQ-011 flush  input  1  kill all in-flight writers (exception/mispredict).
REQ-012 cmpl_valid  input  1  variable-latency unit (MULT/DIV) result available.
REQ-013 cmpl_waddr  input  5  GPR written by cmpl.
REQ-014 issue_cnt  output  clog2(ISSUE_W+1)  number of leading lanes accepted this cycle.
REQ-015 stall_req  output  1  lane 0 valid and not accepted.
REQ-016 busy  output  32  per-GPR pending bits (debug/verification).

Function
REQ-017 Per GPR r (1..31): state {pending, cnt[LAT_W-1:0], var}; GPR 0 never pending, writes to 0 ignored.
REQ-018 Lane i is hazard-free if: valid; neither nonzero source is pending; no nonzero source equals lane_waddr of an earlier lane j<i with lane_we[j] (intra-bundle RAW).
REQ-019 issue_cnt = index of first lane that is invalid or hazardous (in-order, prefix acceptance); issue_cnt = 0 whenever hold or flush is 1.
REQ-020 Combinational: issue_cnt/stall_req depend on same-cycle inputs and current state; no registered latency.
REQ-021 On accepted lane with we and waddr != 0: next cycle pending=1; lat>0 -> cnt=lat, var=0; lat=0 -> var=1, cnt unchanged.
REQ-022 WAW in bundle: higher-numbered accepted lane's entry wins.
REQ-023 Each cycle with hold=0: fixed entries with cnt>1 decrement; cnt=1 clears pending next cycle (latency L -> pending for exactly L cycles after accept).
REQ-024 hold=1: all countdowns frozen; cmpl still honoured.
REQ-025 cmpl_valid with cmpl_waddr matching a var entry clears it next cycle; mismatched/non-var cmpl ignored.
REQ-026 Simultaneous issue to r and expiry/cmpl of r: new issue wins (r stays pending with new values).
REQ-027 flush: all entries cleared next cycle; flush has priority over issue, countdown and cmpl.
REQ-028 Operands reading a pending register never issue; forwarding of non-pending values is the ID stage's job.

Reset
REQ-029 rst=1 at a clock edge clears every pending, var and cnt; outputs combinationally reflect empty scoreboard (issue_cnt = count of leading valid lanes only if hold=0).
REQ-030 rst has priority over flush, cmpl and issue; rst mid-countdown discards all entries.

Structure
REQ-031 Scoreboard entry struct and LAT_W default belong in the shared cpu_defs package.
REQ-032 One sub-module, cpu_sb_entry (one GPR's pending/cnt/var register with decrement/clear logic), instantiated 31 times; prefix-accept logic stays in top.

Verification
REQ-033 Load-use: lane0 LW $5 lat=2 accepted; next cycle lane0 ADDU $6,$5,$5 -> issue_cnt=0, stall_req=1 for 2 cycles, then issue_cnt>=1.
REQ-034 Intra-bundle RAW: lane0 writes $3, lane1 reads $3, both valid, empty board -> issue_cnt=1; next cycle lane1 presented as lane0 stalls on $3 per lat.
REQ-035 Variable latency: DIV writes $8 lat=0; reader of $8 stalls 20 cycles until cmpl_valid=1,cmpl_waddr=8; accepted cycle after; cmpl_waddr=9 has no effect.
REQ-036 Hold: $4 lat=3 pending, hold=1 for 5 cycles -> busy[4] stays 1 throughout, clears 3 unheld cycles after accept.
REQ-037 Flush vs issue: flush=1 with pending $2,$7 and valid writer lane -> issue_cnt=0, busy=0 next cycle.
REQ-038 Reset mid-operation: rst=1 with $10 var-pending -> busy=0 next cycle; late cmpl for $10 ignored; $0 reader/writer never stalls.
